// File: rtl/pwm_ramp_sequencer_pkg.sv
// Shared types and helpers for the PWM ramp sequencer (package pwm_seq_pkg).
package pwm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAMP     = 2'd1,
    HOLD     = 2'd2,
    STOPPING = 2'd3
  } seq_state_t;

  localparam int unsigned W_DEF = 8;

  function automatic int unsigned clamp(input int unsigned a, input int unsigned mx);
    return (a > mx) ? mx : a;
  endfunction

endpackage

// File: rtl/pwm_ramp_sequencer_stepper.sv
// Combinational duty stepper: moves duty toward tgt by stp, saturating at tgt.
module pwm_duty_stepper
  import pwm_seq_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic [W-1:0] duty_i,
  input  logic [W-1:0] tgt_i,
  input  logic [W-1:0] stp_i,
  output logic [W-1:0] duty_next_o,
  output logic         at_tgt_o
);

  logic [W:0]   sum;
  logic [W-1:0] gap;

  always_comb begin
    sum         = {1'b0, duty_i} + {1'b0, stp_i};
    gap         = duty_i - tgt_i;
    duty_next_o = duty_i;
    // Extra carry bit on the way up, gap compare on the way down: never wraps.
    if (duty_i < tgt_i) begin
      duty_next_o = (sum > {1'b0, tgt_i}) ? tgt_i : sum[W-1:0];
    end else if (duty_i > tgt_i) begin
      duty_next_o = (gap <= stp_i) ? tgt_i : (duty_i - stp_i);
    end
    at_tgt_o = (duty_next_o == tgt_i);
  end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// PWM ramp sequencer: ramps PWM duty toward commanded targets once per period.
// Optional soft stop (ramp down before disabling) selected by PWM_SEQ_SOFTSTOP_EN.
module pwm_ramp_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         io_cmd_valid,
  output logic         io_cmd_ready,
  input  logic [W-1:0] io_cmd_target,
  input  logic [W-1:0] io_cmd_period,
  input  logic [W-1:0] io_cmd_step,
  input  logic         io_stop,
  input  logic [W-1:0] io_pwm_cont,
  output logic         io_pwm_inc,
  output logic [W-1:0] io_pwm_T,
  output logic [W-1:0] io_pwm_duty,
  output logic         io_busy,
  output logic [1:0]   io_state
);

  seq_state_t   state_q;
  logic         inc_q;
  logic [W-1:0] t_q, duty_q, tgt_q, stp_q;

  logic [W-1:0] t_d, tgt_idle_d, tgt_hold_d, stp_d, duty_d;
  logic         at_tgt, accept, boundary;

  assign io_cmd_ready = ((state_q == IDLE) || (state_q == HOLD)) && !io_stop;
  assign accept       = io_cmd_valid && io_cmd_ready;
  assign boundary     = inc_q && (io_pwm_cont == t_q);

  assign t_d        = (io_cmd_period == '0) ? W'(1) : io_cmd_period;
  assign stp_d      = (io_cmd_step == '0) ? W'(1) : io_cmd_step;
  assign tgt_idle_d = W'(clamp(32'(io_cmd_target), 32'(t_d)));
  assign tgt_hold_d = W'(clamp(32'(io_cmd_target), 32'(t_q)));

  pwm_duty_stepper #(.W(W)) u_stepper (
    .duty_i      (duty_q),
    .tgt_i       (tgt_q),
    .stp_i       (stp_q),
    .duty_next_o (duty_d),
    .at_tgt_o    (at_tgt)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      inc_q   <= 1'b0;
      t_q     <= '0;
      duty_q  <= '0;
      tgt_q   <= '0;
      stp_q   <= W'(1);
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            t_q     <= t_d;
            tgt_q   <= tgt_idle_d;
            stp_q   <= stp_d;
            duty_q  <= '0;
            inc_q   <= 1'b1;
            state_q <= (tgt_idle_d == '0) ? HOLD : RAMP;
          end
        end
        RAMP, HOLD: begin
          if (io_stop) begin
`ifdef PWM_SEQ_SOFTSTOP_EN
            tgt_q   <= '0;
            state_q <= STOPPING;
`else
            duty_q  <= '0;
            inc_q   <= 1'b0;
            state_q <= IDLE;
`endif
          end else if ((state_q == HOLD) && accept) begin
            tgt_q   <= tgt_hold_d;
            stp_q   <= stp_d;
            state_q <= (tgt_hold_d != duty_q) ? RAMP : HOLD;
          end else if ((state_q == RAMP) && boundary) begin
            duty_q <= duty_d;
            if (at_tgt) state_q <= HOLD;
          end
        end
        STOPPING: begin
`ifdef PWM_SEQ_SOFTSTOP_EN
          // Final zero-duty period completes before the PWM is disabled.
          if (boundary) begin
            if (duty_q == '0) begin
              inc_q   <= 1'b0;
              state_q <= IDLE;
            end else begin
              duty_q <= duty_d;
            end
          end
`else
          duty_q  <= '0;
          inc_q   <= 1'b0;
          state_q <= IDLE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io_pwm_inc  = inc_q;
  assign io_pwm_T    = t_q;
  assign io_pwm_duty = duty_q;
  assign io_busy     = (state_q != IDLE);
  assign io_state    = state_q;

endmodule
